// File: rtl/imm_decode_stage.sv
// RISC-V immediate decode stage: extracts and formats the immediate, registers it with the beat.
// Latency 1 cycle; registered output slot plus one skid slot, in_ready registered as !skid_full.
module imm_decode_stage #(
   parameter int XLEN     = 32,
   parameter bit ZICSR_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   typedef enum logic [2:0] {
      FMT_NONE  = 3'd0,
      FMT_I     = 3'd1,
      FMT_S     = 3'd2,
      FMT_B     = 3'd3,
      FMT_U     = 3'd4,
      FMT_J     = 3'd5,
      FMT_SHAMT = 3'd6,
      FMT_CSR   = 3'd7
   } fmt_e;

   logic [XLEN-1:0] dec_imm;
   fmt_e            dec_fmt;
   logic            dec_illegal;

   logic [6:0] opcode;
   logic [2:0] funct3;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];

   // Size casts of signed slices give the sign extension; unsigned slices zero-extend.
   always_comb begin
      dec_imm     = '0;
      dec_fmt     = FMT_NONE;
      dec_illegal = 1'b0;
      case (opcode)
         7'b0000011, 7'b1100111: begin
            dec_fmt = FMT_I;
            dec_imm = XLEN'($signed(in_instr[31:20]));
         end
         7'b0010011: begin
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_fmt = FMT_SHAMT;
               if (XLEN == 64) begin
                  dec_imm = XLEN'(in_instr[25:20]);
               end else begin
                  dec_imm     = XLEN'(in_instr[24:20]);
                  dec_illegal = in_instr[25];
               end
            end else begin
               dec_fmt = FMT_I;
               dec_imm = XLEN'($signed(in_instr[31:20]));
            end
         end
         7'b0100011: begin
            dec_fmt = FMT_S;
            dec_imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
         end
         7'b1100011: begin
            dec_fmt = FMT_B;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                     in_instr[11:8], 1'b0}));
         end
         7'b0110111, 7'b0010111: begin
            dec_fmt = FMT_U;
            dec_imm = XLEN'($signed({in_instr[31:12], 12'b0}));
         end
         7'b1101111: begin
            dec_fmt = FMT_J;
            dec_imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                     in_instr[30:21], 1'b0}));
         end
         7'b1110011: begin
            // Only the CSR immediate forms (funct3 101/110/111) carry an immediate.
            if (ZICSR_EN && funct3[2] && (funct3[1:0] != 2'b00)) begin
               dec_fmt = FMT_CSR;
               dec_imm = XLEN'(in_instr[19:15]);
            end
         end
         7'b0110011, 7'b0001111: begin
            dec_fmt = FMT_NONE;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   logic            skid_full;
   logic            skid_full_nxt;
   logic [31:0]     skid_instr;
   logic [XLEN-1:0] skid_imm;
   fmt_e            skid_fmt;
   logic            skid_illegal;

   logic accept;
   logic load_out;

   assign accept   = in_valid && in_ready;
   assign load_out = !out_valid || out_ready;

   always_comb begin
      skid_full_nxt = skid_full;
      if (load_out) begin
         skid_full_nxt = 1'b0;
      end else if (accept) begin
         skid_full_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_instr    <= '0;
         out_imm      <= '0;
         out_fmt      <= FMT_NONE;
         out_illegal  <= 1'b0;
         skid_full    <= 1'b0;
         skid_instr   <= '0;
         skid_imm     <= '0;
         skid_fmt     <= FMT_NONE;
         skid_illegal <= 1'b0;
         in_ready     <= 1'b1;
      end else begin
         if (load_out) begin
            // A full skid slot implies in_ready was low, so no new beat competes with it.
            if (skid_full) begin
               out_valid   <= 1'b1;
               out_instr   <= skid_instr;
               out_imm     <= skid_imm;
               out_fmt     <= skid_fmt;
               out_illegal <= skid_illegal;
            end else if (accept) begin
               out_valid   <= 1'b1;
               out_instr   <= in_instr;
               out_imm     <= dec_imm;
               out_fmt     <= dec_fmt;
               out_illegal <= dec_illegal;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (accept) begin
            skid_instr   <= in_instr;
            skid_imm     <= dec_imm;
            skid_fmt     <= dec_fmt;
            skid_illegal <= dec_illegal;
         end
         skid_full <= skid_full_nxt;
         in_ready  <= !skid_full_nxt;
      end
   end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32, XLEN=64 and ZICSR_EN=0 instances share stimulus.
module tb_imm_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] in_instr;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_out_illegal;
   logic [31:0] a_out_instr, a_out_imm;
   logic [2:0]  a_out_fmt;

   logic        b_in_ready, b_out_valid, b_out_illegal;
   logic [31:0] b_out_instr;
   logic [63:0] b_out_imm;
   logic [2:0]  b_out_fmt;

   logic        c_in_ready, c_out_valid, c_out_illegal;
   logic [31:0] c_out_instr, c_out_imm;
   logic [2:0]  c_out_fmt;

   int chk_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .ZICSR_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .out_valid(a_out_valid), .out_ready(out_ready),
      .out_instr(a_out_instr), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_illegal(a_out_illegal)
   );

   imm_decode_stage #(.XLEN(64), .ZICSR_EN(1'b1)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .out_valid(b_out_valid), .out_ready(out_ready),
      .out_instr(b_out_instr), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_illegal(b_out_illegal)
   );

   imm_decode_stage #(.XLEN(32), .ZICSR_EN(1'b0)) dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
      .in_instr(in_instr), .out_valid(c_out_valid), .out_ready(out_ready),
      .out_instr(c_out_instr), .out_imm(c_out_imm), .out_fmt(c_out_fmt),
      .out_illegal(c_out_illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [31:0] imm32;
      logic [63:0] imm64;
      logic        ill32;
      logic        ill64;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs[NVEC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0};
      vecs[1]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
      vecs[2]  = '{32'hFE000CE3, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8, 1'b0, 1'b0};
      vecs[3]  = '{32'h001000EF, 3'd5, 32'h00000800, 64'h00000000_00000800, 1'b0, 1'b0};
      vecs[4]  = '{32'h03F09093, 3'd6, 32'h0000001F, 64'h00000000_0000003F, 1'b1, 1'b0};
      vecs[5]  = '{32'h00000000, 3'd0, 32'h00000000, 64'h0, 1'b1, 1'b1};
      vecs[6]  = '{32'h0050D073, 3'd7, 32'h00000001, 64'h1, 1'b0, 1'b0};
      vecs[7]  = '{32'h12345037, 3'd4, 32'h12345000, 64'h00000000_12345000, 1'b0, 1'b0};
      vecs[8]  = '{32'h80000037, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0, 1'b0};
      vecs[9]  = '{32'h00B50533, 3'd0, 32'h00000000, 64'h0, 1'b0, 1'b0};
      vecs[10] = '{32'h0000000F, 3'd0, 32'h00000000, 64'h0, 1'b0, 1'b0};
      vecs[11] = '{32'h00000073, 3'd0, 32'h00000000, 64'h0, 1'b0, 1'b0};
      vecs[12] = '{32'h7FF02083, 3'd1, 32'h000007FF, 64'h00000000_000007FF, 1'b0, 1'b0};
      vecs[13] = '{32'h40105093, 3'd6, 32'h00000001, 64'h1, 1'b0, 1'b0};
      vecs[14] = '{32'h00000012, 3'd0, 32'h00000000, 64'h0, 1'b1, 1'b1};
      vecs[15] = '{32'h0000007F, 3'd0, 32'h00000000, 64'h0, 1'b1, 1'b1};
      vecs[16] = '{32'hFFC08067, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0, 1'b0};
      vecs[17] = '{32'h0007F073, 3'd7, 32'h0000000F, 64'hF, 1'b0, 1'b0};

      // Reset with a beat offered: it must never appear.
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst out_valid", 64'(a_out_valid), 64'd0);
      check("rst in_ready", 64'(a_in_ready), 64'd1);
      check("rst out_imm", 64'(a_out_imm), 64'd0);
      check("rst out_fmt", 64'(a_out_fmt), 64'd0);
      check("rst out_instr", 64'(a_out_instr), 64'd0);
      check("rst out_illegal", 64'(a_out_illegal), 64'd0);
      check("rst b out_valid", 64'(b_out_valid), 64'd0);
      rst_n    = 1'b1;
      in_valid = 1'b0;
      tick();
      check("post-rst out_valid", 64'(a_out_valid), 64'd0);

      // Back-to-back table: each beat shows one cycle after acceptance.
      for (int i = 0; i < NVEC; i++) begin
         logic sys;
         in_valid = 1'b1;
         in_instr = vecs[i].instr;
         tick();
         sys = (vecs[i].instr[6:0] == 7'b1110011);
         check($sformatf("v%0d valid", i), 64'(a_out_valid), 64'd1);
         check($sformatf("v%0d in_ready", i), 64'(a_in_ready), 64'd1);
         check($sformatf("v%0d instr", i), 64'(a_out_instr), 64'(vecs[i].instr));
         check($sformatf("v%0d imm32", i), 64'(a_out_imm), 64'(vecs[i].imm32));
         check($sformatf("v%0d fmt32", i), 64'(a_out_fmt), 64'(vecs[i].fmt));
         check($sformatf("v%0d ill32", i), 64'(a_out_illegal), 64'(vecs[i].ill32));
         check($sformatf("v%0d imm64", i), b_out_imm, vecs[i].imm64);
         check($sformatf("v%0d fmt64", i), 64'(b_out_fmt), 64'(vecs[i].fmt));
         check($sformatf("v%0d ill64", i), 64'(b_out_illegal), 64'(vecs[i].ill64));
         check($sformatf("v%0d nocsr imm", i), 64'(c_out_imm), sys ? 64'd0 : 64'(vecs[i].imm32));
         check($sformatf("v%0d nocsr fmt", i), 64'(c_out_fmt), sys ? 64'd0 : 64'(vecs[i].fmt));
         check($sformatf("v%0d nocsr ill", i), 64'(c_out_illegal), 64'(vecs[i].ill32));
      end
      in_valid = 1'b0;
      tick();
      check("drain out_valid", 64'(a_out_valid), 64'd0);

      // Stall: A in output slot, B in skid, C refused until the skid empties.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFFF00093;
      tick();
      check("stall A valid", 64'(a_out_valid), 64'd1);
      check("stall A instr", 64'(a_out_instr), 64'hFFF00093);
      check("stall in_ready after A", 64'(a_in_ready), 64'd1);
      in_instr = 32'hFE112E23;
      tick();
      check("stall hold A", 64'(a_out_instr), 64'hFFF00093);
      check("stall in_ready after B", 64'(a_in_ready), 64'd0);
      in_instr = 32'h001000EF;
      tick();
      check("stall hold A 2", 64'(a_out_instr), 64'hFFF00093);
      check("stall hold A imm", 64'(a_out_imm), 64'hFFFFFFFF);
      check("stall in_ready low", 64'(a_in_ready), 64'd0);
      out_ready = 1'b1;
      tick();
      check("release B valid", 64'(a_out_valid), 64'd1);
      check("release B instr", 64'(a_out_instr), 64'hFE112E23);
      check("release B imm", 64'(a_out_imm), 64'hFFFFFFFC);
      check("release B fmt", 64'(a_out_fmt), 64'd2);
      check("release in_ready", 64'(a_in_ready), 64'd1);
      tick();
      check("release C instr", 64'(a_out_instr), 64'h001000EF);
      check("release C imm", 64'(a_out_imm), 64'h00000800);
      in_valid = 1'b0;
      tick();
      check("release empty", 64'(a_out_valid), 64'd0);

      // Reset during a full stall discards both held beats.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'h12345037;
      tick();
      in_instr = 32'h7FF02083;
      tick();
      check("pre-rst skid full", 64'(a_in_ready), 64'd0);
      rst_n    = 1'b0;
      in_instr = 32'h0050D073;
      tick();
      check("mid-rst out_valid", 64'(a_out_valid), 64'd0);
      check("mid-rst in_ready", 64'(a_in_ready), 64'd1);
      check("mid-rst out_instr", 64'(a_out_instr), 64'd0);
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("post-rst idle %0d", k), 64'(a_out_valid), 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values 32 and 64 only.
REQ-002 SHALL have parameter ZICSR_EN, default 1; 1 = decode CSR immediate forms, 0 = treat SYSTEM as no-immediate.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept a beat.
REQ-007 SHALL have port in_instr  input  32  raw instruction word.
REQ-008 SHALL have port out_valid  output  1  output beat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the beat.
REQ-010 SHALL have port out_instr  output  32  instruction passed through unchanged.
REQ-011 SHALL have port out_imm  output  XLEN  decoded immediate.
REQ-012 SHALL have port out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SHAMT, 7 CSR.
REQ-013 SHALL have port out_illegal  output  1  word not decodable by this stage.

Function
REQ-014 SHALL transfer an input beat when in_valid && in_ready and an output beat when out_valid && out_ready.
REQ-015 SHALL present an accepted beat on the outputs exactly 1 cycle after acceptance when the output register is empty or draining; sustained throughput 1 beat/cycle.
REQ-016 SHALL hold a registered output slot plus one skid slot; in_ready SHALL be a registered signal equal to NOT skid_full.
REQ-017 Output stalled (out_valid && !out_ready) and beat accepted: beat SHALL go to skid slot; in_ready SHALL be 0 from the next cycle.
REQ-018 Output drains while skid full: skid contents SHALL move to the output slot that edge; in_ready SHALL return to 1 the next cycle.
REQ-019 Output drains while skid empty and input accepted in the same cycle: the new beat SHALL load the output slot directly.
REQ-020 Beats SHALL leave in acceptance order, with no loss or duplication; outputs SHALL stay stable while out_valid && !out_ready.
REQ-021 I format applies to opcodes 0000011, 1100111, and 0010011 with funct3 not 001/101: sign-extend instr[31:20] to XLEN.
REQ-022 S format applies to opcode 0100011: sign-extend {instr[31:25],instr[11:7]}.
REQ-023 B format applies to opcode 1100011: sign-extend {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-024 U format applies to opcodes 0110111 and 0010111: {instr[31:12],12'b0}, sign-extended to XLEN.
REQ-025 J format applies to opcode 1101111: sign-extend {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}.
REQ-026 SHAMT format applies to opcode 0010011 with funct3 001/101: zero-extend instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
REQ-027 SHAMT when XLEN=32 and instr[25]=1: out_illegal SHALL be 1.
REQ-028 CSR format applies when ZICSR_EN=1, opcode 1110011 and funct3 101/110/111: zero-extend instr[19:15]; other SYSTEM funct3 SHALL give fmt NONE and imm 0.
REQ-029 Opcodes 0110011 and 0001111, and SYSTEM when ZICSR_EN=0, SHALL give fmt NONE, imm 0, illegal 0.
REQ-030 Any other opcode, or instr[1:0] != 2'b11, SHALL give fmt NONE, imm 0, illegal 1.
REQ-031 Decode SHALL be computed on input and registered with the beat, with no combinational path from in_instr to any output.

Reset
REQ-032 While rst_n=0 at a clock edge: out_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_instr=0, out_illegal=0, skid cleared, all from the next cycle.
REQ-033 Reset asserted mid-stall SHALL discard both held beats; no beat accepted during the reset cycle SHALL appear.

Verification
REQ-034 in_instr 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_imm 0xFFFFFFFF, fmt 1.
REQ-035 Back-to-back 0xFE112E23, 0xFE000CE3, 0x001000EF -> on consecutive cycles imm 0xFFFFFFFC fmt 2; 0xFFFFFFF8 fmt 3; 0x00000800 fmt 5.
REQ-036 XLEN=64, 0x03F09093 -> imm 63, fmt 6, illegal 0; XLEN=32 same word -> illegal 1.
REQ-037 in_valid held high, out_ready low 3 cycles -> 2 beats held, in_ready low after the second; on release, beats drain in order, no loss or duplication.
REQ-038 rst_n low for 1 cycle during the REQ-037 stall -> out_valid 0 and in_ready 1 the next cycle; held beats never appear.
REQ-039 in_instr 0x00000000 -> fmt 0, imm 0, illegal 1; 0x0050D073 (csrrwi) with ZICSR_EN=1 -> imm 1, fmt 7.
